// File: rtl/gemm_sa_pkg.sv
// Shared types for the gemm_sa weight-stationary systolic array.
package GEMM_pkg;

   typedef enum logic [1:0] {
      CMD_NONE          = 2'd0,
      CMD_WRITE_WEIGHTS = 2'd1,
      CMD_STREAM        = 2'd2
   } command_t;

endpackage

// File: rtl/gemm_sa_if.sv
// Controller-to-array bus for gemm_sa; out_valid exists only with GEMM_OUT_VALID_EN.
interface gemm_sa_if #(
   parameter int SA_SIZE         = 4,
   parameter int ACTIVATION_SIZE = 8
);
   import GEMM_pkg::*;

   logic [SA_SIZE-1:0][SA_SIZE-1:0][ACTIVATION_SIZE-1:0] weight_inputs;
   logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]              activation_inputs;
   logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]              activation_outputs;
   command_t                                             cmd;
`ifdef GEMM_OUT_VALID_EN
   logic                                                 out_valid;
`endif

   modport master (
      output weight_inputs, activation_inputs, cmd,
`ifdef GEMM_OUT_VALID_EN
      input  out_valid,
`endif
      input  activation_outputs
   );

   modport slave (
      input  weight_inputs, activation_inputs, cmd,
`ifdef GEMM_OUT_VALID_EN
      output out_valid,
`endif
      output activation_outputs
   );

endinterface

// File: rtl/gemm_sa_pe.sv
// One processing element: stationary weight, pass-through activation, wrapping MAC into psum.
module gemm_pe #(
   parameter int ACTIVATION_SIZE = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_w,
   input  logic                       en,
   input  logic [ACTIVATION_SIZE-1:0] w_in,
   input  logic [ACTIVATION_SIZE-1:0] a_in,
   input  logic [ACTIVATION_SIZE-1:0] psum_in,
   output logic [ACTIVATION_SIZE-1:0] a_out,
   output logic [ACTIVATION_SIZE-1:0] psum_out
);

   logic [ACTIVATION_SIZE-1:0] w_q;
   logic [ACTIVATION_SIZE-1:0] a_p1;
   logic [ACTIVATION_SIZE-1:0] psum_p1;

   // Unsigned multiply-accumulate, keeping only the low ACTIVATION_SIZE bits.
   function automatic logic [ACTIVATION_SIZE-1:0] mac_wrap(
      input logic [ACTIVATION_SIZE-1:0] acc,
      input logic [ACTIVATION_SIZE-1:0] a,
      input logic [ACTIVATION_SIZE-1:0] w
   );
      logic [2*ACTIVATION_SIZE-1:0] prod;
      prod = a * w;
      return acc + prod[ACTIVATION_SIZE-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         w_q     <= '0;
         a_p1    <= '0;
         psum_p1 <= '0;
      end else begin
         if (load_w) begin
            w_q <= w_in;
         end
         if (en) begin
            a_p1    <= a_in;
            psum_p1 <= mac_wrap(psum_in, a_in, w_q);
         end
      end
   end

   assign a_out    = a_p1;
   assign psum_out = psum_p1;

endmodule

// File: rtl/gemm_sa.sv
// Weight-stationary SA_SIZE x SA_SIZE systolic array computing O = I x W (mod 2^ACTIVATION_SIZE).
// Optional GEMM_OUT_VALID_EN adds out_valid, marking rows that carry an accepted input row.
module gemm_sa
   import GEMM_pkg::*;
#(
   parameter int SA_SIZE         = 4,
   parameter int ACTIVATION_SIZE = 8
) (
   input  logic       clk,
   input  logic       reset,
   gemm_sa_if.slave   sa
);

   localparam int N  = SA_SIZE;
   localparam int AW = ACTIVATION_SIZE;

   logic stream_en;
   logic load_w;

   always_comb begin
      stream_en = (sa.cmd == CMD_STREAM);
      load_w    = (sa.cmd == CMD_WRITE_WEIGHTS);
   end

   // a_h[r][c] feeds PE(r,c); p_v[r][c] is the psum entering PE(r,c), p_v[N] leaves the array.
   logic [AW-1:0] a_h           [N][N];
   logic [AW-1:0] p_v           [N+1][N];
   logic [AW-1:0] a_edge_unused [N];
   logic [AW-1:0] col_out       [N];
   logic [N-1:0][AW-1:0] out_p1;

   for (genvar r = 0; r < N; r++) begin : g_row
      // Input skew: lane r waits r stream steps so it meets the psum wavefront.
      if (r == 0) begin : g_noskew
         assign a_h[0][0] = sa.activation_inputs[0];
      end else begin : g_skew
         logic [AW-1:0] skew_p0 [r];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int j = 0; j < r; j++) skew_p0[j] <= '0;
            end else if (stream_en) begin
               skew_p0[0] <= sa.activation_inputs[r];
               for (int j = 1; j < r; j++) skew_p0[j] <= skew_p0[j-1];
            end
         end
         assign a_h[r][0] = skew_p0[r-1];
      end

      for (genvar c = 0; c < N; c++) begin : g_col
         logic [AW-1:0] a_out;
         if (r == 0) begin : g_top
            assign p_v[0][c] = '0;
         end
         gemm_pe #(.ACTIVATION_SIZE(AW)) u_pe (
            .clk      (clk),
            .reset    (reset),
            .load_w   (load_w),
            .en       (stream_en),
            .w_in     (sa.weight_inputs[r][c]),
            .a_in     (a_h[r][c]),
            .psum_in  (p_v[r][c]),
            .a_out    (a_out),
            .psum_out (p_v[r+1][c])
         );
         if (c < N-1) begin : g_pass
            assign a_h[r][c+1] = a_out;
         end else begin : g_edge
            assign a_edge_unused[r] = a_out;
         end
      end
   end

   // Output deskew: column c is delayed N-1-c steps so a whole O row lines up.
   for (genvar c = 0; c < N; c++) begin : g_deskew
      if (c == N-1) begin : g_direct
         assign col_out[c] = p_v[N][c];
      end else begin : g_chain
         localparam int D = N - 1 - c;
         logic [AW-1:0] dsk_p2 [D];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int j = 0; j < D; j++) dsk_p2[j] <= '0;
            end else if (stream_en) begin
               dsk_p2[0] <= p_v[N][c];
               for (int j = 1; j < D; j++) dsk_p2[j] <= dsk_p2[j-1];
            end
         end
         assign col_out[c] = dsk_p2[D-1];
      end
   end

   // Output register stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_p1 <= '0;
      end else if (stream_en) begin
         for (int c = 0; c < N; c++) out_p1[c] <= col_out[c];
      end
   end

   assign sa.activation_outputs = out_p1;

`ifdef GEMM_OUT_VALID_EN
   logic [2*N-1:0] vld_sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_sr <= '0;
      end else if (stream_en) begin
         vld_sr <= {vld_sr[2*N-2:0], 1'b1};
      end
   end

   assign sa.out_valid = vld_sr[2*N-1];
`endif

endmodule

// File: tb/tb_gemm_sa.sv
// Scoreboard bench for gemm_sa: stimulus pushes expected O rows, a monitor pops them on stream edges.
module tb_gemm_sa;
   import GEMM_pkg::*;

   localparam int N   = 4;
   localparam int AW  = 8;
   localparam int LAT = 2*N - 1;

   typedef logic [N-1:0][AW-1:0]         row_t;
   typedef logic [N-1:0][N-1:0][AW-1:0]  mat_t;
   typedef struct { row_t data; logic vld; } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gemm_sa_if #(.SA_SIZE(N), .ACTIVATION_SIZE(AW)) bus ();

   gemm_sa #(.SA_SIZE(N), .ACTIVATION_SIZE(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .sa    (bus)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   w_model [N][N];
   bit   started  = 1'b0;

   // O row = I row x W, plain integer arithmetic then modulo 2^AW.
   function automatic row_t ref_row(input row_t a);
      row_t res;
      for (int c = 0; c < N; c++) begin
         int acc;
         acc = 0;
         for (int r = 0; r < N; r++) acc += int'(a[r]) * w_model[r][c];
         res[c] = AW'(acc % 256);
      end
      return res;
   endfunction

   task automatic check_row(input string name, input row_t act, input row_t req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
      end
   endtask

   function automatic row_t rand_row();
      row_t r;
      for (int i = 0; i < N; i++) r[i] = AW'($urandom_range(0, 255));
      return r;
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) m[r][c] = AW'($urandom_range(0, 255));
      return m;
   endfunction

   // Drive tasks: set inputs on the falling edge, return just after the rising edge.
   task automatic do_reset();
      exp_t z;
      @(negedge clk);
      started = 1'b1;
      reset = 1'b1;
      bus.cmd = CMD_NONE;
      exp_q.delete();
      z.data = '0;
      z.vld  = 1'b0;
      for (int i = 0; i < LAT; i++) exp_q.push_back(z);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) w_model[r][c] = 0;
      @(posedge clk); #2;
   endtask

   task automatic load_w(input mat_t w);
      @(negedge clk);
      reset = 1'b0;
      bus.cmd = CMD_WRITE_WEIGHTS;
      bus.weight_inputs = w;
      bus.activation_inputs = rand_row();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) w_model[r][c] = int'(w[r][c]);
      @(posedge clk); #2;
   endtask

   task automatic stream(input row_t a);
      exp_t e;
      @(negedge clk);
      reset = 1'b0;
      bus.cmd = CMD_STREAM;
      bus.activation_inputs = a;
      bus.weight_inputs = rand_mat();
      e.data = ref_row(a);
      e.vld  = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #2;
   endtask

   task automatic idle(input logic [1:0] code);
      @(negedge clk);
      reset = 1'b0;
      bus.cmd = command_t'(code);
      bus.activation_inputs = rand_row();
      @(posedge clk); #2;
   endtask

   task automatic drain();
      for (int i = 0; i < LAT; i++) stream('0);
   endtask

   // Monitor: pops one expected row per stream edge, otherwise expects outputs frozen.
   initial begin
      command_t c_s;
      logic     r_s;
      row_t     prev_out;
      logic     prev_v;
      exp_t     e;
      prev_out = '0;
      prev_v   = 1'b0;
      forever begin
         @(posedge clk);
         c_s = bus.cmd;
         r_s = reset;
         #1;
         if (started) begin
            if (r_s) begin
               check_row("reset_out", bus.activation_outputs, '0);
`ifdef GEMM_OUT_VALID_EN
               check_bit("reset_valid", bus.out_valid, 1'b0);
`endif
               prev_out = '0;
               prev_v   = 1'b0;
            end else if (c_s == CMD_STREAM) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL scoreboard_underflow: got empty queue required an entry at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  check_row("stream_row", bus.activation_outputs, e.data);
`ifdef GEMM_OUT_VALID_EN
                  check_bit("stream_valid", bus.out_valid, e.vld);
`endif
                  prev_out = e.data;
                  prev_v   = e.vld;
               end
            end else begin
               check_row("hold_row", bus.activation_outputs, prev_out);
`ifdef GEMM_OUT_VALID_EN
               check_bit("hold_valid", bus.out_valid, prev_v);
`endif
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mat_t w;
      row_t a;
      reset = 1'b1;
      bus.cmd = CMD_NONE;
      bus.weight_inputs = '0;
      bus.activation_inputs = '0;

      // Diagonal weights, five counting rows then zero padding.
      do_reset();
      w = '0;
      for (int r = 0; r < N; r++) w[r][r] = AW'(r + 1);
      load_w(w);
      for (int i = 0; i < 12; i++) begin
         a = '0;
         if (i < 5) for (int r = 0; r < N; r++) a[r] = AW'(4*i + r + 1);
         stream(a);
         if (i == 7)  check_row("diag_first",  bus.activation_outputs, {8'd16, 8'd9, 8'd4, 8'd1});
         if (i == 11) check_row("diag_last",   bus.activation_outputs, {8'd80, 8'd57, 8'd36, 8'd17});
      end

      // Wraparound: every weight and activation 255.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) w[r][c] = 8'd255;
      load_w(w);
      for (int i = 0; i < 8; i++) begin
         a = (i == 0) ? {N{8'd255}} : '0;
         stream(a);
         if (i == 7) check_row("wrap_row", bus.activation_outputs, {8'd4, 8'd4, 8'd4, 8'd4});
      end

      // Random weights, contiguous stream.
      for (int t = 0; t < 3; t++) begin
         load_w(rand_mat());
         for (int i = 0; i < 5; i++) stream(rand_row());
         drain();
      end

      // Random stream with hold cycles (CMD_NONE and an unlisted encoding) mixed in.
      load_w(rand_mat());
      for (int i = 0; i < 5 + LAT; i++) begin
         stream((i < 5) ? rand_row() : row_t'('0));
         for (int k = 0; k < int'($urandom_range(0, 2)); k++)
            idle(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3);
      end

      // Reset mid-stream: weights clear, later rows come out as zeros.
      load_w(rand_mat());
      for (int i = 0; i < 3; i++) stream(rand_row());
      do_reset();
      for (int i = 0; i < 8; i++) stream(rand_row());
      drain();

      // Reload after drain: second batch must use only the new weights.
      load_w(rand_mat());
      for (int i = 0; i < 4; i++) stream(rand_row());
      drain();
      load_w(rand_mat());
      for (int i = 0; i < 4; i++) stream(rand_row());
      drain();

      idle(2'd0);
      idle(2'd0);

      n_checks++;
      if (exp_q.size() != LAT) begin
         n_errors++;
         $display("FAIL queue_depth: got %0d required %0d", exp_q.size(), LAT);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/gemm_sa.md
Name: gemm_sa

Overview:
- Weight-stationary SA_SIZE x SA_SIZE systolic-array matrix multiplier.
- Computes O = I x W, where W is a square weight matrix loaded in parallel and I is streamed one row per cycle.
- Result rows emerge in order, one per streaming cycle, after a fixed pipeline latency.
- Used as the compute core of the accelerator datapath, driven by a command input from the controller.

Parameters:
- SA_SIZE, 4, array dimension N: weight matrix is N x N, activation/output vectors are N lanes.
- ACTIVATION_SIZE, 8, bit width of activations, weights, partial sums and outputs.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- weight_inputs  input  [SA_SIZE][SA_SIZE] x ACTIVATION_SIZE  W[r][c], captured on CMD_WRITE_WEIGHTS.
- activation_inputs  input  [SA_SIZE] x ACTIVATION_SIZE  one row of I; lane r multiplies weight row r.
- activation_outputs  output  [SA_SIZE] x ACTIVATION_SIZE  one row of O; lane c = column c.
- cmd  input  command_t  CMD_NONE / CMD_WRITE_WEIGHTS / CMD_STREAM.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset: all state (weights, input skew regs, PE activation/psum regs, output deskew regs) clears to 0; activation_outputs = 0 from the first edge with reset high. Reset mid-stream discards all in-flight data.
- CMD_WRITE_WEIGHTS: on the edge, every PE(r,c) latches weight_inputs[r][c] in one cycle. Streaming pipeline does not advance.
- CMD_STREAM: on the edge, the whole pipeline advances one step and activation_inputs is accepted as the next row of I.
- CMD_NONE, or any unlisted encoding: pipeline and weights hold; activation_outputs stable.
- Arithmetic: O[i][c] = sum over r of I[i][r]*W[r][c], modulo 2^ACTIVATION_SIZE (unsigned, wrap, no saturation). Each PE computes psum_out = psum_in + a*w, truncated to ACTIVATION_SIZE bits. Row 0 psum_in = 0.
- Dataflow:
  - Activation lane r is skewed by r registers and enters PE row r.
  - Activations pass right across columns; psums pass down rows.
  - Column c output is deskewed by (N-1-c) registers so that all lanes of one O row present simultaneously.
- Latency:
  - A row accepted on stream edge k appears on activation_outputs immediately after stream edge k+2N-1 (N=4: edge 7). Latency counts only CMD_STREAM edges.
  - Before the first valid row, outputs show results of zero/reset contents; zero-padding rows give 0-row contributions.
  - To drain M input rows, issue M+2N-1 CMD_STREAM cycles total, using zero inputs after the data.
- Weights may be reloaded while data is in flight. In-flight rows then use mixed weights; the controller must drain first.

Optional Feature:
- Macro GEMM_OUT_VALID_EN.
- Defined:
  - Adds output port out_valid (1 bit, reset 0).
  - A shift register of per-row valid bits advances with CMD_STREAM. A bit is set when that stream edge's row is accepted.
  - out_valid is high exactly when activation_outputs holds an O row, i.e. 2N-1 stream edges after acceptance.
  - Flush rows fed while a separate input tag is absent are not counted. Every accepted CMD_STREAM row is treated as valid.
- Undefined: no port; behaviour otherwise identical.

Decomposition:
- Package GEMM_pkg: typedef enum logic [1:0] command_t {CMD_NONE=0, CMD_WRITE_WEIGHTS=1, CMD_STREAM=2}.
- Sub-module gemm_pe: weight reg, activation pass reg, psum reg, enable, MAC.
- Top instantiates N x N gemm_pe plus skew/deskew register chains.

Test Plan:
- Diagonal W=diag(1,2,3,4), I rows [1,2,3,4]..[17,18,19,20], then 7 zero rows -> output after stream edge 7 = [1,4,9,16]; after edge 11 = [17,36,57,80].
- Wrap check: all W=255, I row all 255 -> output row [4,4,4,4] (255*255 mod 256 = 1, times 4).
- Random W and 5 random I rows, 12 stream cycles -> rows after edges 7..11 equal (I x W) mod 256.
- Hold: insert CMD_NONE cycles between stream cycles -> outputs frozen during NONE; final results identical to contiguous run.
- Reset asserted after 3 stream cycles -> outputs 0 next edge; weights cleared; subsequent stream with zero weights yields all-zero rows.
- Weight reload: load W1, stream and drain, load W2, stream -> second batch results use W2 only.
